lab9_ocm_loader: RTL
====================

# lab9_ocm_loader

Avalon-MM master stage that sits directly upstream of the 4-word, 32-bit on-chip memory slave in the lab9 SoC. It accepts one 128-bit block over a valid/ready handshake and writes it into the OCM as four 32-bit words. With verification enabled, it then reads the four words back and reports per-word mismatches. It gives the AES datapath a deterministic, cycle-exact way to load the OCM without the Nios master.

## Interface
- `VERIFY`, default 1: 1 enables the readback/compare phase; 0 skips it.
- `WORDS`, default 4: number of OCM words. Fixed at 4 for this SoC.
- `ADDR_W`, default 2: OCM address width.
- `clk`  in  1  system clock; all logic sits on this one clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream block valid.
- `in_ready`  out  1  loader idle; accepts a block when high.
- `in_data`  in  128  block; bits [127:96] form word 0 (big-endian word order).
- `done`  out  1  one-cycle pulse when the sequence is complete.
- `err_mask`  out  4  bit i set means readback word i ≠ written word i; valid from `done` until the next accept.
- `rd_data`  out  128  readback block, same word order as `in_data`.
- `ocm_address`  out  ADDR_W  Avalon address.
- `ocm_chipselect`  out  1  Avalon chipselect.
- `ocm_write`  out  1  Avalon write.
- `ocm_byteenable`  out  4  always 4'hF while chipselect is high, else 0.
- `ocm_writedata`  out  32  write word.
- `ocm_readdata`  in  32  read word; 1-cycle read latency.
- `ocm_clken`  out  1  RAM clock enable; 0 in reset, 1 afterwards.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: `in_ready`=1. When `in_valid`&`in_ready`, latch `in_data`, clear `err_mask`, clear the word counter `idx`, and go to WRITE.
- WRITE: drive chipselect=1, write=1, address=`idx`, writedata=word `idx`. Increment `idx`. After `idx`=3, go to READ (VERIFY=1) or DONE (VERIFY=0), and reset `idx` to 0.
- READ: drive chipselect=1, write=0, address=`idx`. Increment `idx`. After `idx`=3, go to DRAIN.
- Capture: `ocm_readdata` is sampled one cycle after its address was issued, into `rd_data` word `idx-1`. The compare result for that word is written into `err_mask` in the same cycle.
- DRAIN: chipselect=0. Capture word 3, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `rd_data` and `err_mask` hold until the next accept.
- `in_valid` while not IDLE is ignored; the block must stay presented until accepted. No block is lost or duplicated.
- VERIFY=0: `rd_data`=0 and `err_mask`=0 always.
- All Avalon outputs are registered. Write and read never overlap.

## Timing
- Reset values: `in_ready`=0 while `reset_n`=0 and 1 in the first cycle after release. `done`=0, `err_mask`=0, `rd_data`=0. `ocm_address`=0, `ocm_chipselect`=0, `ocm_write`=0, `ocm_byteenable`=0, `ocm_writedata`=0, `ocm_clken`=0. FSM state is IDLE.
- Cycle numbering: accept edge = cycle 0.
- Writes occur in cycles 1–4 at addresses 0,1,2,3.
- VERIFY=1: reads issued in cycles 5–8; captures in cycles 6–9; `done` in cycle 10; `in_ready` high again in cycle 11. Throughput is one block per 11 cycles.
- VERIFY=0: `done` in cycle 5; `in_ready` in cycle 6.
- Back-to-back: `in_valid` held high yields an accept in cycle 11 (VERIFY=1) or cycle 6 (VERIFY=0).
- Reset mid-sequence: all outputs return to their reset values asynchronously and the FSM returns to IDLE. A partially written OCM is left as is, and `done` is never pulsed for the aborted block.

## Structure
- Package `lab9_ocm_pkg` holds:
  - the state enum (`ocm_ld_state_t`);
  - the constants `OCM_WORDS`=4 and `OCM_ADDR_W`=2;
  - the function `ocm_word(block, idx)` returning bits [127-32*idx -: 32].
- No sub-module; a single flat module with one FSM, the `idx` counter, and the capture registers.

## Test plan
- Reset then release, no stimulus: all outputs stay at reset values except `in_ready`=1 and `ocm_clken`=1.
- Load 128'h00112233_44556677_8899AABB_CCDDEEFF with a behavioural OCM model:
  - writes 00112233@0, 44556677@1, 8899AABB@2, CCDDEEFF@3 in cycles 1–4;
  - `done` in cycle 10, `err_mask`=4'b0000, `rd_data`=the input block.
- Same block, with the model corrupting word 2 reads to 8899AABA: `err_mask`=4'b0100 and `rd_data`[63:32]=8899AABA.
- `in_valid` held high with two blocks queued: second accept in cycle 11, no Avalon activity in cycle 0 of the second block, and the first result held until the second accept.
- Assert `reset_n` low in cycle 3 (mid-WRITE): chipselect/write drop immediately, no `done` pulse, and a fresh block after release completes normally.
- VERIFY=0 build, load 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE: four writes, `done` in cycle 5, no read cycles issued, `err_mask`=0.

Source files
------------

// File: rtl/lab9_ocm_pkg.sv
// Shared definitions for the lab9 OCM loader: FSM encoding, OCM geometry
// and helpers that map a 128-bit block onto big-endian-ordered 32-bit words.
package lab9_ocm_pkg;

  localparam int OCM_WORDS  = 4;
  localparam int OCM_ADDR_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ocm_ld_state_t;

  // Word 0 lives in the most significant 32 bits of the block.
  function automatic logic [31:0] ocm_word(input logic [127:0] block, input logic [1:0] idx);
    logic [31:0] w_word;
    case (idx)
      2'd0:    w_word = block[127:96];
      2'd1:    w_word = block[95:64];
      2'd2:    w_word = block[63:32];
      2'd3:    w_word = block[31:0];
      default: w_word = 32'h0000_0000;
    endcase
    return w_word;
  endfunction

  function automatic logic [127:0] ocm_put(input logic [127:0] block, input logic [1:0] idx,
                                           input logic [31:0] word);
    logic [127:0] w_blk;
    w_blk = block;
    case (idx)
      2'd0:    w_blk[127:96] = word;
      2'd1:    w_blk[95:64]  = word;
      2'd2:    w_blk[63:32]  = word;
      2'd3:    w_blk[31:0]   = word;
      default: w_blk         = block;
    endcase
    return w_blk;
  endfunction

endpackage

// File: rtl/lab9_ocm_loader.sv
// Avalon-MM master that writes one 128-bit block into the 4-word OCM and,
// when VERIFY is set, reads it back and flags per-word mismatches.
module lab9_ocm_loader
  import lab9_ocm_pkg::*;
#(
  parameter bit VERIFY = 1'b1,
  parameter int WORDS  = OCM_WORDS,
  parameter int ADDR_W = OCM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic              done,
  output logic [3:0]        err_mask,
  output logic [127:0]      rd_data,
  output logic [ADDR_W-1:0] ocm_address,
  output logic              ocm_chipselect,
  output logic              ocm_write,
  output logic [3:0]        ocm_byteenable,
  output logic [31:0]       ocm_writedata,
  input  logic [31:0]       ocm_readdata,
  output logic              ocm_clken
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

  ocm_ld_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [127:0]      r_blk, w_blk_nxt;
  logic              r_in_ready, r_done, r_cs, r_wr, r_clken;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              w_cs_nxt, w_wr_nxt;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [127:0]      r_rd_data, w_rd_data_nxt;
  logic [3:0]        r_err_mask, w_err_nxt;
  logic              w_accept;

  assign w_accept = in_valid & r_in_ready;

  // Sequencer: accept, four writes, optional four reads plus drain, done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_blk_nxt   = r_blk;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_WRITE;
          w_idx_nxt   = {ADDR_W{1'b0}};
          w_blk_nxt   = in_data;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (r_idx == LAST_IDX) begin
          w_idx_nxt = {ADDR_W{1'b0}};
          if (VERIFY) begin
            w_state_nxt = ST_READ;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      ST_READ: begin
        if (r_idx == LAST_IDX) begin
          w_idx_nxt   = {ADDR_W{1'b0}};
          w_state_nxt = ST_DRAIN;
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus values are decoded from the next state so they register alongside it.
  always_comb begin
    w_cs_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_addr_nxt  = {ADDR_W{1'b0}};
    w_wdata_nxt = 32'h0000_0000;
    case (w_state_nxt)
      ST_WRITE: begin
        w_cs_nxt    = 1'b1;
        w_wr_nxt    = 1'b1;
        w_addr_nxt  = w_idx_nxt;
        w_wdata_nxt = ocm_word(w_blk_nxt, 2'(w_idx_nxt));
      end
      ST_READ: begin
        w_cs_nxt   = 1'b1;
        w_addr_nxt = w_idx_nxt;
      end
      default: w_cs_nxt = 1'b0;
    endcase
  end

  // Readback capture: the word addressed two edges ago is on ocm_readdata now.
  always_comb begin
    w_rd_data_nxt = r_rd_data;
    w_err_nxt     = r_err_mask;
    if (w_accept) begin
      w_err_nxt = 4'h0;
    end else if (r_rd_pend) begin
      w_rd_data_nxt       = ocm_put(r_rd_data, 2'(r_rd_idx), ocm_readdata);
      w_err_nxt[r_rd_idx] = (ocm_readdata != ocm_word(r_blk, 2'(r_rd_idx)));
    end else begin
      w_err_nxt = r_err_mask;
    end
  end

  // FSM, counter, block latch and registered Avalon outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= {ADDR_W{1'b0}};
      r_blk      <= 128'h0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
      r_cs       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_be       <= 4'h0;
      r_wdata    <= 32'h0000_0000;
      r_clken    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_blk      <= w_blk_nxt;
      r_in_ready <= (w_state_nxt == ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
      r_cs       <= w_cs_nxt;
      r_wr       <= w_wr_nxt;
      r_addr     <= w_addr_nxt;
      r_be       <= w_cs_nxt ? 4'hF : 4'h0;
      r_wdata    <= w_wdata_nxt;
      r_clken    <= 1'b1;
    end
  end

  // Read-latency tracking and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_idx   <= {ADDR_W{1'b0}};
      r_rd_data  <= 128'h0;
      r_err_mask <= 4'h0;
    end else begin
      r_rd_pend  <= r_cs & ~r_wr;
      r_rd_idx   <= r_addr;
      r_rd_data  <= w_rd_data_nxt;
      r_err_mask <= w_err_nxt;
    end
  end

  assign in_ready       = r_in_ready;
  assign done           = r_done;
  assign err_mask       = r_err_mask;
  assign rd_data        = r_rd_data;
  assign ocm_address    = r_addr;
  assign ocm_chipselect = r_cs;
  assign ocm_write      = r_wr;
  assign ocm_byteenable = r_be;
  assign ocm_writedata  = r_wdata;
  assign ocm_clken      = r_clken;

endmodule
